mbisr_repair_engine: RTL and testbench

//  Next-generation MBISR repair engine. It sits between the BIST fail port, the user port and the

---
 rtl/mbisr_repair_engine.sv | 194 +++++++++++++++++++
 tb/tb_mbisr_repair_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mbisr_repair_engine.sv
// MBISR repair engine: remaps failing user addresses onto a spare-row window.
// Fails arrive over valid/ready and are handled by a CHECK/ALLOC/RELOC FSM.
module mbisr_repair_engine #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_REPAIRS = 16,
  parameter logic [ADDR_WIDTH-1:0] SPARE_BASE = 'hF0,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fail_valid,
  input  logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  fail_ready,
  input  logic                  repair_lock,
  input  logic                  repair_clear,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  input  logic [DATA_WIDTH-1:0] user_wdata,
  input  logic                  user_we,
  input  logic                  user_en,
  output logic [DATA_WIDTH-1:0] user_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  user_hit,
  output logic [CNT_WIDTH-1:0]  repair_count,
  output logic                  repair_full,
  output logic                  repair_overflow,
  output logic                  busy
);

  localparam int IW = (MAX_REPAIRS > 1) ? $clog2(MAX_REPAIRS) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, ALLOC, RELOC} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [IW-1:0]           k_q, k_d;
  logic [MAX_REPAIRS-1:0]  valid_q, valid_d;
  logic [MAX_REPAIRS-1:0]  bad_q, bad_d;
  logic [ADDR_WIDTH-1:0]   tbl_q [MAX_REPAIRS];
  logic [ADDR_WIDTH-1:0]   tbl_d [MAX_REPAIRS];
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic                    full_q, full_d;
  logic                    ovf_q, ovf_d;

  logic [ADDR_WIDTH-1:0]   off;
  logic [IW-1:0]           kw;
  logic                    in_win;
  logic                    dup;
  logic                    free_found;
  logic [IW-1:0]           free_idx;

  assign fail_ready      = (state_q == IDLE) && !repair_lock;
  assign busy            = (state_q != IDLE);
  assign repair_count    = count_q;
  assign repair_full     = full_q;
  assign repair_overflow = ovf_q;
  assign mem_wdata       = user_wdata;
  assign mem_we          = user_we;
  assign mem_en          = user_en;
  assign user_rdata      = mem_rdata;

  // Window test on the latched address; offset arithmetic wraps naturally.
  always_comb begin
    off    = addr_q - SPARE_BASE;
    kw     = off[IW-1:0];
    in_win = ({1'b0, off} < (ADDR_WIDTH+1)'(MAX_REPAIRS));
  end

  // Duplicate detection and lowest free, non-bad slot (RELOC skips k).
  always_comb begin
    dup        = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < MAX_REPAIRS; i++) begin
      if (valid_q[i] && tbl_q[i] == addr_q) dup = 1'b1;
    end
    for (int i = MAX_REPAIRS-1; i >= 0; i--) begin
      if (!valid_q[i] && !bad_q[i] &&
          !(state_q == RELOC && IW'(i) == k_q)) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // FSM next state and table update; clear overrides everything.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    k_d     = k_q;
    valid_d = valid_q;
    bad_d   = bad_q;
    tbl_d   = tbl_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (fail_valid && fail_ready) begin
          addr_d  = fail_addr;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (in_win) begin
          bad_d[kw] = 1'b1;
          if (valid_q[kw]) begin
            addr_d  = tbl_q[kw];
            k_d     = kw;
            state_d = RELOC;
          end else begin
            state_d = IDLE;
          end
        end else if (dup) begin
          state_d = IDLE;
        end else begin
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        if (free_found) begin
          valid_d[free_idx] = 1'b1;
          tbl_d[free_idx]   = addr_q;
        end else begin
          ovf_d = 1'b1;
        end
        state_d = IDLE;
      end
      RELOC: begin
        valid_d[k_q] = 1'b0;
        if (free_found) begin
          valid_d[free_idx] = 1'b1;
          tbl_d[free_idx]   = addr_q;
        end else begin
          ovf_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (repair_clear) begin
      state_d = IDLE;
      valid_d = '0;
      bad_d   = '0;
      ovf_d   = 1'b0;
      for (int i = 0; i < MAX_REPAIRS; i++) tbl_d[i] = '1;
    end
    count_d = '0;
    for (int i = 0; i < MAX_REPAIRS; i++) begin
      count_d = count_d + CNT_WIDTH'(valid_d[i]);
    end
    full_d = &(valid_d | bad_d);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      k_q     <= '0;
      valid_q <= '0;
      bad_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < MAX_REPAIRS; i++) tbl_q[i] <= '1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
      count_q <= count_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      tbl_q   <= tbl_d;
    end
  end

  // User-path remap; lowest matching index wins.
  always_comb begin
    user_hit = 1'b0;
    mem_addr = user_addr;
    for (int i = MAX_REPAIRS-1; i >= 0; i--) begin
      if (valid_q[i] && tbl_q[i] == user_addr) begin
        user_hit = 1'b1;
        mem_addr = SPARE_BASE + ADDR_WIDTH'(i);
      end
    end
  end

endmodule

// File: tb/tb_mbisr_repair_engine.sv
// Directed bench for mbisr_repair_engine.
// Linear step sequence with immediate assertions.
module tb_mbisr_repair_engine;

  logic       clk, rst;
  logic       fail_valid, fail_ready;
  logic [7:0] fail_addr;
  logic       repair_lock, repair_clear;
  logic [7:0] user_addr, user_wdata, user_rdata;
  logic       user_we, user_en;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, mem_en;
  logic       user_hit;
  logic [4:0] repair_count;
  logic       repair_full, repair_overflow, busy;

  int total = 0;
  int bad   = 0;
  int nb;

  mbisr_repair_engine dut (
    .clk(clk), .rst(rst),
    .fail_valid(fail_valid), .fail_addr(fail_addr),
    .fail_ready(fail_ready),
    .repair_lock(repair_lock), .repair_clear(repair_clear),
    .user_addr(user_addr), .user_wdata(user_wdata),
    .user_we(user_we), .user_en(user_en),
    .user_rdata(user_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
    .mem_rdata(mem_rdata), .user_hit(user_hit),
    .repair_count(repair_count), .repair_full(repair_full),
    .repair_overflow(repair_overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, output int n);
    int w;
    w = 0;
    while (!fail_ready && w < 20) begin
      cyc();
      w++;
    end
    chk("send_ready", 32'(fail_ready), 1);
    fail_valid = 1'b1;
    fail_addr  = a;
    cyc();
    fail_valid = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      n++;
      cyc();
    end
  endtask

  task automatic umap(input string tag, input logic [7:0] ua,
                      input logic [7:0] ma, input logic h);
    user_addr = ua;
    #1;
    chk({tag, "_addr"}, 32'(mem_addr), 32'(ma));
    chk({tag, "_hit"}, 32'(user_hit), 32'(h));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fail_valid = 1'b0;
    fail_addr = '0;
    repair_lock = 1'b0;
    repair_clear = 1'b0;
    user_addr = '0;
    user_wdata = '0;
    user_we = 1'b0;
    user_en = 1'b0;
    mem_rdata = '0;
    cyc();
    cyc();
    rst = 1'b0;

    // reset values
    chk("rst_count", 32'(repair_count), 0);
    chk("rst_full", 32'(repair_full), 0);
    chk("rst_ovf", 32'(repair_overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(fail_ready), 1);

    // pass-through data path
    user_wdata = 8'hA5; user_we = 1'b1; user_en = 1'b1;
    mem_rdata = 8'h3C;
    #1;
    chk("pt_wdata", 32'(mem_wdata), 32'hA5);
    chk("pt_we", 32'(mem_we), 1);
    chk("pt_en", 32'(mem_en), 1);
    chk("pt_rdata", 32'(user_rdata), 32'h3C);
    user_we = 1'b0; user_en = 1'b0;

    // 1: two fails
    send(8'h12, nb);
    chk("t1_busy_alloc", 32'(nb), 2);
    send(8'h34, nb);
    chk("t1_count", 32'(repair_count), 2);
    umap("t1_12", 8'h12, 8'hF0, 1'b1);
    umap("t1_34", 8'h34, 8'hF1, 1'b1);
    umap("t1_35", 8'h35, 8'h35, 1'b0);

    // 2: duplicate filtered, CHECK only
    do_reset();
    send(8'h12, nb);
    chk("t2_first_busy", 32'(nb), 2);
    send(8'h12, nb);
    chk("t2_dup_busy", 32'(nb), 1);
    chk("t2_count", 32'(repair_count), 1);

    // 3: fill table and overflow
    do_reset();
    for (int i = 0; i < 15; i++) send(8'h20 + 8'(i), nb);
    chk("t3_full15", 32'(repair_full), 0);
    send(8'h2F, nb);
    chk("t3_full16", 32'(repair_full), 1);
    chk("t3_count16", 32'(repair_count), 16);
    chk("t3_ovf16", 32'(repair_overflow), 0);
    umap("t3_2f", 8'h2F, 8'hFF, 1'b1);
    send(8'h40, nb);
    chk("t3_ovf17", 32'(repair_overflow), 1);
    chk("t3_count17", 32'(repair_count), 16);
    umap("t3_40", 8'h40, 8'h40, 1'b0);

    // 4: spare retirement with relocation
    do_reset();
    send(8'h12, nb);
    umap("t4_pre", 8'h12, 8'hF0, 1'b1);
    send(8'hF0, nb);
    chk("t4_busy_reloc", 32'(nb), 2);
    umap("t4_post", 8'h12, 8'hF1, 1'b1);
    chk("t4_count", 32'(repair_count), 1);
    umap("t4_win", 8'hF0, 8'hF0, 1'b0);

    // 5a: lock refuses fails
    repair_lock = 1'b1;
    fail_valid = 1'b1;
    fail_addr = 8'h55;
    #1;
    chk("t5_ready_lock", 32'(fail_ready), 0);
    cyc(); cyc(); cyc();
    chk("t5_busy_lock", 32'(busy), 0);
    chk("t5_count_lock", 32'(repair_count), 1);
    umap("t5_55", 8'h55, 8'h55, 1'b0);
    fail_valid = 1'b0;
    repair_lock = 1'b0;

    // 5b: clear during CHECK
    fail_valid = 1'b1;
    fail_addr = 8'h66;
    cyc();
    fail_valid = 1'b0;
    chk("t5_in_check", 32'(busy), 1);
    repair_clear = 1'b1;
    cyc();
    repair_clear = 1'b0;
    chk("t5_clr_count", 32'(repair_count), 0);
    chk("t5_clr_busy", 32'(busy), 0);
    cyc(); cyc();
    chk("t5_clr_abort", 32'(repair_count), 0);
    umap("t5_12", 8'h12, 8'h12, 1'b0);
    umap("t5_66", 8'h66, 8'h66, 1'b0);

    // 6: reset during ALLOC
    send(8'h12, nb);
    fail_valid = 1'b1;
    fail_addr = 8'h77;
    cyc();
    fail_valid = 1'b0;
    cyc();
    chk("t6_in_alloc", 32'(busy), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_count", 32'(repair_count), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ready", 32'(fail_ready), 1);
    chk("t6_full", 32'(repair_full), 0);
    chk("t6_ovf", 32'(repair_overflow), 0);
    umap("t6_77", 8'h77, 8'h77, 1'b0);
    umap("t6_12", 8'h12, 8'h12, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
